aes_block_serializer: RTL and testbench
=======================================

Name: aes_block_serializer

Overview:
- Parametrised block-to-word serializer for the AES256 datapath: captures one N_BYTES-byte state block, then emits it as BEATS = N_BYTES/W_BYTES words of W_BYTES bytes each.
- Sits between the cipher core output and the AXI-side word interface.
- Generalises the fixed 16-to-4 register with:
  - configurable widths and beat order
  - valid/ready handshakes on both sides
  - last/beat-index sideband
  - synchronous flush
  - optional double buffering

Parameters:
- N_BYTES, 16: block size in bytes; must be a multiple of W_BYTES.
- W_BYTES, 4: output word size in bytes; BEATS = N_BYTES/W_BYTES, at least 2.
- LSB_FIRST, 1:
  - 1: beat k carries bytes k*W_BYTES .. k*W_BYTES+W_BYTES-1.
  - 0: beats are emitted in reverse order, starting at beat BEATS-1.
- Local parameter BW = max(1, $clog2(BEATS)).

Ports:
- clk  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous abort; clears all buffered data
- i_valid  input  1  input block valid
- i_ready  output  1  block can be accepted this cycle
- i_data  input  N_BYTES*8  block; byte j = i_data[8j+:8]
- o_valid  output  1  output word valid
- o_ready  input  1  downstream accepts word
- o_data  output  W_BYTES*8  word; byte j of the beat at o_data[8j+:8]
- o_last  output  1  current beat is the final beat of the block
- o_beat  output  BW  index of the current beat within the block
- busy  output  1  any block held (active or pending)

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; buffers cleared to 0; beat counter 0; o_valid=0, o_data=0, o_last=0, o_beat=0, busy=0. i_ready=1 in the first cycle after reset release.
- States:
  - IDLE: no block held.
  - DRAIN: active buffer being emitted.
- Input accept: occurs on a clk edge with i_valid && i_ready. i_data is captured into the active buffer, state goes to DRAIN, and the counter is loaded with the first beat index (0, or BEATS-1 when LSB_FIRST=0).
- Latency: o_valid=1 in the cycle after accept, presenting the first beat.
- Output drive: o_data, o_last and o_beat are driven from registered buffer and counter state only; no combinational path from i_data or o_ready.
- o_data while valid: holds active[beat].
- o_data while o_valid=0: 0.
- Hold rule: while o_valid && !o_ready, o_data/o_last/o_beat are held stable.
- Output handshake (o_valid && o_ready):
  - Not the last beat: counter steps ±1 according to LSB_FIRST.
  - Last beat, nothing pending: return to IDLE; o_valid=0 next cycle.
- o_last is 1 exactly when the counter is at BEATS-1 (LSB_FIRST=1) or at 0 (LSB_FIRST=0).
- i_ready (base build) = state==IDLE. It is combinational from registered state. Result: one bubble cycle between blocks; throughput is one block per BEATS+1 cycles at o_ready=1.
- i_valid while i_ready=0: ignored; the upstream must hold i_data.
- flush:
  - Has priority over every handshake in the same cycle.
  - Next cycle: IDLE, o_valid=0, counter 0, pending slot empty; buffer contents are don't-care but not emitted.
  - An input offered in the flush cycle is not accepted.
- Reset mid-operation: the block is discarded immediately; nothing partial is emitted afterwards.
- busy = (state==DRAIN) || pending slot full.

Optional Feature:
- Macro: AES_SER_DBUF_EN.
- When defined, a pending buffer plus pending-full flag are added:
  - i_ready = !pending_full.
  - An accept during DRAIN fills the pending slot.
  - On the last-beat handshake with the pending slot full: pending moves to active, the counter reloads, o_valid stays 1, and there is no bubble.
  - On the last-beat handshake coinciding with an accept while pending is empty: i_data loads directly into active, with no bubble.
  - Sustained throughput: one block per BEATS cycles.
  - flush clears the pending slot as well.
- When not defined: no pending storage; base-build behaviour above, with i_ready = state==IDLE.

Test Plan:
- Single block, defaults: reset, then i_data with byte k = k, i.e. 0x0F0E..0100, and o_ready=1 → o_data is 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles. o_beat runs 0..3, o_last=1 only on 0x0F0E0D0C, and o_valid drops the next cycle.
- Backpressure: o_ready=0 for 3 cycles on beat 1 → 0x07060504 and o_beat=1 are held stable; i_ready stays 0 (base build); the sequence resumes intact.
- LSB_FIRST=0, same block → order is 0x0F0E0D0C, 0x0B0A0908, 0x07060504, 0x03020100; o_beat runs 3..0; o_last on 0x03020100.
- Flush after beat 1 handshake, with i_valid also high in the flush cycle → next cycle o_valid=0, busy=0, input not accepted. A new block 0xFF..F0 then emits from beat 0 with no residue.
- AES_SER_DBUF_EN, two back-to-back blocks with o_ready=1 → 8 consecutive valid beats with no gap. The second block is accepted while the first drains; i_ready=0 only while pending is full.
- Async reset asserted mid-block (after beat 2) → outputs go to 0 immediately, without waiting for a clk edge. After release: i_ready=1, busy=0, and no stale beat appears.

Source files
------------

// File: rtl/aes_block_serializer.sv
// Block-to-word serializer: captures one N_BYTES block and emits it as BEATS words of W_BYTES.
// Define AES_SER_DBUF_EN to add a pending buffer so blocks can stream without a bubble.
//   state       | meaning
//   STATE_IDLE  | no block held
//   STATE_DRAIN | active buffer being emitted
module aes_block_serializer #(
    parameter int N_BYTES   = 16,
    parameter int W_BYTES   = 4,
    parameter int LSB_FIRST = 1,
    localparam int BEATS    = N_BYTES / W_BYTES,
    localparam int BW       = ($clog2(BEATS) > 1) ? $clog2(BEATS) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [N_BYTES*8-1:0] i_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [W_BYTES*8-1:0] o_data,
    output logic                 o_last,
    output logic [BW-1:0]        o_beat,
    output logic                 busy
);

    localparam int WW = W_BYTES * 8;
    localparam logic [BW-1:0] FIRST_BEAT = (LSB_FIRST != 0) ? '0 : BW'(BEATS - 1);
    localparam logic [BW-1:0] LAST_BEAT  = (LSB_FIRST != 0) ? BW'(BEATS - 1) : '0;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_DRAIN = 1'b1;

    logic                 state_q;
    logic [N_BYTES*8-1:0] active_q;
    logic [BW-1:0]        beat_q;
    logic [BW-1:0]        beat_step;
    logic                 accept;
    logic                 o_fire;
    logic                 at_last;
    logic                 pend_full;

`ifdef AES_SER_DBUF_EN
    logic [N_BYTES*8-1:0] pending_q;
    logic                 pending_full_q;

    assign pend_full = pending_full_q;
    assign i_ready   = !pending_full_q;
`else
    assign pend_full = 1'b0;
    assign i_ready   = (state_q == STATE_IDLE);
`endif

    assign accept    = i_valid && i_ready;
    assign o_valid   = (state_q == STATE_DRAIN);
    assign o_fire    = o_valid && o_ready;
    assign at_last   = (beat_q == LAST_BEAT);
    assign beat_step = (LSB_FIRST != 0) ? beat_q + BW'(1) : beat_q - BW'(1);

    assign o_last = o_valid && at_last;
    assign o_beat = beat_q;
    assign busy   = o_valid || pend_full;

    always_comb begin
        o_data = '0;
        if (o_valid) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat_q == BW'(k)) o_data = active_q[k*WW +: WW];
            end
        end
    end

    // flush is checked ahead of all handshakes, so a block offered with it is dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= STATE_IDLE;
            active_q <= '0;
            beat_q   <= '0;
`ifdef AES_SER_DBUF_EN
            pending_q      <= '0;
            pending_full_q <= 1'b0;
`endif
        end else if (flush) begin
            state_q <= STATE_IDLE;
            beat_q  <= '0;
`ifdef AES_SER_DBUF_EN
            pending_full_q <= 1'b0;
`endif
        end else if (state_q == STATE_IDLE) begin
            if (accept) begin
                active_q <= i_data;
                state_q  <= STATE_DRAIN;
                beat_q   <= FIRST_BEAT;
            end
        end else if (o_fire && at_last) begin
`ifdef AES_SER_DBUF_EN
            if (pending_full_q) begin
                active_q       <= pending_q;
                beat_q         <= FIRST_BEAT;
                pending_full_q <= 1'b0;
            end else if (accept) begin
                active_q <= i_data;
                beat_q   <= FIRST_BEAT;
            end else begin
                state_q <= STATE_IDLE;
                beat_q  <= '0;
            end
`else
            state_q <= STATE_IDLE;
            beat_q  <= '0;
`endif
        end else begin
            if (o_fire) beat_q <= beat_step;
`ifdef AES_SER_DBUF_EN
            if (accept) begin
                pending_q      <= i_data;
                pending_full_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench for aes_block_serializer: forward and reverse beat order instances share stimulus.
module tb_aes_block_serializer;

    localparam logic [127:0] BLK_A = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK_F = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;

`ifdef AES_SER_DBUF_EN
    localparam logic RDY_DRAIN = 1'b1;
    localparam int   DROP_AT   = 2;
`else
    localparam logic RDY_DRAIN = 1'b0;
    localparam int   DROP_AT   = 6;
`endif

    logic         clk;
    logic         resetn;
    logic         flush;
    logic         i_valid;
    logic [127:0] i_data;
    logic         o_ready;

    logic         i_ready, o_valid, o_last, busy;
    logic [31:0]  o_data;
    logic [1:0]   o_beat;
    logic         r_i_ready, r_o_valid, r_o_last, r_busy;
    logic [31:0]  r_o_data;
    logic [1:0]   r_o_beat;

    int n_assert = 0;
    int n_fail   = 0;

    aes_block_serializer #(.N_BYTES(16), .W_BYTES(4), .LSB_FIRST(1)) u_dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_last(o_last), .o_beat(o_beat), .busy(busy)
    );

    aes_block_serializer #(.N_BYTES(16), .W_BYTES(4), .LSB_FIRST(0)) u_rev (
        .clk(clk), .resetn(resetn), .flush(flush),
        .i_valid(i_valid), .i_ready(r_i_ready), .i_data(i_data),
        .o_valid(r_o_valid), .o_ready(o_ready), .o_data(r_o_data),
        .o_last(r_o_last), .o_beat(r_o_beat), .busy(r_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f_data;
        logic [1:0]  f_beat;
        logic        f_last;
        logic [31:0] r_data;
        logic [1:0]  r_beat;
        logic        r_last;
    } beat_vec_t;

    typedef struct {
        logic        v;
        logic [31:0] data;
        logic [1:0]  beat;
        logic        last;
        logic        rdy;
    } cyc_vec_t;

    beat_vec_t tbl_a[4];
    logic [31:0] words_f[4];
    cyc_vec_t  b2b[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] b, input logic l);
        chk({tag, "_valid"}, 64'(o_valid), 64'(v));
        chk({tag, "_data"},  64'(o_data),  64'(d));
        chk({tag, "_beat"},  64'(o_beat),  64'(b));
        chk({tag, "_last"},  64'(o_last),  64'(l));
    endtask

    task automatic chk_rev(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] b, input logic l);
        chk({tag, "_rvalid"}, 64'(r_o_valid), 64'(v));
        chk({tag, "_rdata"},  64'(r_o_data),  64'(d));
        chk({tag, "_rbeat"},  64'(r_o_beat),  64'(b));
        chk({tag, "_rlast"},  64'(r_o_last),  64'(l));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl_a[0] = '{32'h03020100, 2'd0, 1'b0, 32'h0F0E0D0C, 2'd3, 1'b0};
        tbl_a[1] = '{32'h07060504, 2'd1, 1'b0, 32'h0B0A0908, 2'd2, 1'b0};
        tbl_a[2] = '{32'h0B0A0908, 2'd2, 1'b0, 32'h07060504, 2'd1, 1'b0};
        tbl_a[3] = '{32'h0F0E0D0C, 2'd3, 1'b1, 32'h03020100, 2'd0, 1'b1};
        words_f[0] = 32'hF3F2F1F0;
        words_f[1] = 32'hF7F6F5F4;
        words_f[2] = 32'hFBFAF9F8;
        words_f[3] = 32'hFFFEFDFC;
`ifdef AES_SER_DBUF_EN
        b2b[0] = '{1'b1, 32'h03020100, 2'd0, 1'b0, 1'b1};
        b2b[1] = '{1'b1, 32'h07060504, 2'd1, 1'b0, 1'b0};
        b2b[2] = '{1'b1, 32'h0B0A0908, 2'd2, 1'b0, 1'b0};
        b2b[3] = '{1'b1, 32'h0F0E0D0C, 2'd3, 1'b1, 1'b0};
        b2b[4] = '{1'b1, 32'hF3F2F1F0, 2'd0, 1'b0, 1'b1};
        b2b[5] = '{1'b1, 32'hF7F6F5F4, 2'd1, 1'b0, 1'b1};
        b2b[6] = '{1'b1, 32'hFBFAF9F8, 2'd2, 1'b0, 1'b1};
        b2b[7] = '{1'b1, 32'hFFFEFDFC, 2'd3, 1'b1, 1'b1};
        b2b[8] = '{1'b0, 32'h0,        2'd0, 1'b0, 1'b1};
        b2b[9] = '{1'b0, 32'h0,        2'd0, 1'b0, 1'b1};
`else
        b2b[0] = '{1'b1, 32'h03020100, 2'd0, 1'b0, 1'b0};
        b2b[1] = '{1'b1, 32'h07060504, 2'd1, 1'b0, 1'b0};
        b2b[2] = '{1'b1, 32'h0B0A0908, 2'd2, 1'b0, 1'b0};
        b2b[3] = '{1'b1, 32'h0F0E0D0C, 2'd3, 1'b1, 1'b0};
        b2b[4] = '{1'b0, 32'h0,        2'd0, 1'b0, 1'b1};
        b2b[5] = '{1'b1, 32'hF3F2F1F0, 2'd0, 1'b0, 1'b0};
        b2b[6] = '{1'b1, 32'hF7F6F5F4, 2'd1, 1'b0, 1'b0};
        b2b[7] = '{1'b1, 32'hFBFAF9F8, 2'd2, 1'b0, 1'b0};
        b2b[8] = '{1'b1, 32'hFFFEFDFC, 2'd3, 1'b1, 1'b0};
        b2b[9] = '{1'b0, 32'h0,        2'd0, 1'b0, 1'b1};
`endif

        resetn = 1'b0; flush = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b0;
        #2;
        chk_out("reset", 1'b0, 32'h0, 2'd0, 1'b0);
        chk_rev("reset", 1'b0, 32'h0, 2'd0, 1'b0);
        chk("reset_busy", 64'(busy), 64'(0));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_i_ready", 64'(i_ready), 64'(1));
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk_out("post_rst", 1'b0, 32'h0, 2'd0, 1'b0);

        // single block, both beat orders
        i_valid = 1'b1; i_data = BLK_A; o_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            chk_out($sformatf("single_b%0d", k), 1'b1, tbl_a[k].f_data, tbl_a[k].f_beat, tbl_a[k].f_last);
            chk_rev($sformatf("single_b%0d", k), 1'b1, tbl_a[k].r_data, tbl_a[k].r_beat, tbl_a[k].r_last);
            chk($sformatf("single_i_ready%0d", k), 64'(i_ready), 64'(RDY_DRAIN));
            chk($sformatf("single_busy%0d", k), 64'(busy), 64'(1));
        end
        @(negedge clk);
        chk_out("single_end", 1'b0, 32'h0, 2'd0, 1'b0);
        chk_rev("single_end", 1'b0, 32'h0, 2'd0, 1'b0);
        chk("single_end_busy", 64'(busy), 64'(0));
        chk("single_end_i_ready", 64'(i_ready), 64'(1));

        // backpressure on beat 1
        i_valid = 1'b1; i_data = BLK_A;
        @(negedge clk);
        i_valid = 1'b0;
        chk_out("bp_b0", 1'b1, 32'h03020100, 2'd0, 1'b0);
        @(negedge clk);
        chk_out("bp_b1", 1'b1, 32'h07060504, 2'd1, 1'b0);
        o_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_out($sformatf("bp_hold%0d", c), 1'b1, 32'h07060504, 2'd1, 1'b0);
            chk($sformatf("bp_i_ready%0d", c), 64'(i_ready), 64'(RDY_DRAIN));
        end
        o_ready = 1'b1;
        @(negedge clk);
        chk_out("bp_b2", 1'b1, 32'h0B0A0908, 2'd2, 1'b0);
        @(negedge clk);
        chk_out("bp_b3", 1'b1, 32'h0F0E0D0C, 2'd3, 1'b1);
        @(negedge clk);
        chk_out("bp_end", 1'b0, 32'h0, 2'd0, 1'b0);

        // flush while idle blocks an offered input
        flush = 1'b1; i_valid = 1'b1; i_data = BLK_A;
        @(negedge clk);
        flush = 1'b0; i_valid = 1'b0;
        chk_out("flush_idle", 1'b0, 32'h0, 2'd0, 1'b0);
        chk("flush_idle_busy", 64'(busy), 64'(0));

        // flush after the beat 1 handshake, input offered in the same cycle
        i_valid = 1'b1; i_data = BLK_A;
        @(negedge clk);
        i_valid = 1'b0;
        chk_out("flush_b0", 1'b1, 32'h03020100, 2'd0, 1'b0);
        @(negedge clk);
        chk_out("flush_b1", 1'b1, 32'h07060504, 2'd1, 1'b0);
        @(negedge clk);
        chk_out("flush_b2", 1'b1, 32'h0B0A0908, 2'd2, 1'b0);
        flush = 1'b1; i_valid = 1'b1; i_data = BLK_F;
        @(negedge clk);
        flush = 1'b0;
        chk_out("flush_mid", 1'b0, 32'h0, 2'd0, 1'b0);
        chk("flush_mid_busy", 64'(busy), 64'(0));
        chk("flush_mid_i_ready", 64'(i_ready), 64'(1));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            chk_out($sformatf("flush_new_b%0d", k), 1'b1, words_f[k], 2'(k), (k == 3));
        end
        @(negedge clk);
        chk_out("flush_new_end", 1'b0, 32'h0, 2'd0, 1'b0);

        // two blocks offered back to back
        i_valid = 1'b1; i_data = BLK_A;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) i_data = BLK_F;
            if (n == DROP_AT) i_valid = 1'b0;
            chk_out($sformatf("b2b_c%0d", n), b2b[n-1].v, b2b[n-1].data, b2b[n-1].beat, b2b[n-1].last);
            chk($sformatf("b2b_i_ready%0d", n), 64'(i_ready), 64'(b2b[n-1].rdy));
        end

        // asynchronous reset in the middle of a block
        i_valid = 1'b1; i_data = BLK_A;
        @(negedge clk);
        i_valid = 1'b0;
        chk_out("arst_b0", 1'b1, 32'h03020100, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_out("arst_b2", 1'b1, 32'h0B0A0908, 2'd2, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk_out("arst_now", 1'b0, 32'h0, 2'd0, 1'b0);
        chk_rev("arst_now", 1'b0, 32'h0, 2'd0, 1'b0);
        chk("arst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_out($sformatf("arst_after%0d", c), 1'b0, 32'h0, 2'd0, 1'b0);
            chk($sformatf("arst_i_ready%0d", c), 64'(i_ready), 64'(1));
            chk($sformatf("arst_busy%0d", c), 64'(busy), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
